addsub_result_accumulator: RTL and testbench

Consumer end of the 4-bit adder/subtractor result interface. It accepts {mode, magnitude, flag} result words over a valid/ready handshake and decodes each word to a signed value. It accumulates a frame of a programmed length into a saturating signed sum, then presents the frame total on a valid/ready output. It sits directly downstream of the add/sub datapath and turns per-operation results into a running total for the control logic.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/addsub_decode.sv | 32 +++
 rtl/addsub_result_accumulator.sv | 132 +++++++++++++
 tb/tb_addsub_result_accumulator.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the 4-bit adder/subtractor result interface.
// Holds the result-word mode encoding (common with the add/sub datapath),
// the decoded value width, and the accumulator FSM state encoding.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of a decoded result word: add range 0..31, subtract range -15..15.
  localparam int DEC_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/addsub_decode.sv
// Combinational decoder for one {mode, magnitude, flag} result word.
// Ports:
//   mode - MODE_ADD or MODE_SUB
//   mag  - 4-bit result magnitude / sum bits
//   flag - add: carry out; subtract: negative (borrow) flag
//   dec  - signed DEC_W-bit value of the result word
module addsub_decode
  import addsub_pkg::*;
(
  input  logic             mode,
  input  logic [3:0]       mag,
  input  logic             flag,
  output logic [DEC_W-1:0] dec
);

  logic [DEC_W-1:0] mag_ext;

  assign mag_ext = {2'b00, mag};

  always_comb begin
    dec = '0;
    if (mode == MODE_ADD) begin
      // Carry becomes bit 4 of a non-negative 5-bit sum.
      dec = {1'b0, flag, mag};
    end else if (flag) begin
      dec = -mag_ext;
    end else begin
      dec = mag_ext;
    end
  end

endmodule

// File: rtl/addsub_result_accumulator.sv
// Frame accumulator for add/sub result words.
// Accepts result words over in_valid/in_ready, sums frame_len of them into a
// saturating signed ACC_W-bit total, then offers the total on
// out_valid/out_ready.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid-side data is don't-care while valid is low.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start, frame_len      - begin a frame of frame_len words (IDLE only)
//   in_valid, in_ready    - result word handshake
//   in_mode/in_mag/in_flag- result word fields
//   out_valid, out_ready  - frame total handshake
//   out_sum               - signed frame total (running sum while accumulating)
//   out_count             - words accumulated
//   out_sat               - sticky saturation indicator for the frame
module addsub_result_accumulator
  import addsub_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [3:0]       in_mag,
  input  logic             in_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);

  acc_state_e       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;

  logic [DEC_W-1:0] dec;
  logic [ACC_W:0]   dec_ext;
  logic [ACC_W:0]   sum_wide;
  logic             ovf;
  logic [ACC_W-1:0] sum_clamped;
  logic [CNT_W-1:0] count_inc;
  logic             accept;

  addsub_decode u_decode (
    .mode (in_mode),
    .mag  (in_mag),
    .flag (in_flag),
    .dec  (dec)
  );

  // One extra bit of headroom: overflow shows as the top two bits differing.
  assign dec_ext  = {{(ACC_W + 1 - DEC_W){dec[DEC_W-1]}}, dec};
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + dec_ext;
  assign ovf      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  always_comb begin
    sum_clamped = sum_wide[ACC_W-1:0];
    if (ovf) begin
      sum_clamped = sum_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                    : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign count_inc = count_q + CNT_W'(1);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (start && (frame_len != '0)) begin
          len_d   = frame_len;
          count_d = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d   = sum_clamped;
          sat_d   = sat_q | ovf;
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  assign out_sum   = acc_q;
  assign out_count = count_q;
  assign out_sat   = sat_q;

endmodule

// File: tb/tb_addsub_result_accumulator.sv
// Directed bench for addsub_result_accumulator. Instance a uses ACC_W = 12,
// instance b uses ACC_W = 6 for saturation; they share all inputs except
// start, and only one is ever out of IDLE at a time.
module tb_addsub_result_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [3:0]  frame_len = '0;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic [3:0]  in_mag = '0;
  logic        in_flag = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [11:0] out_sum_a;
  logic [3:0]  out_count_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [5:0]  out_sum_b;
  logic [3:0]  out_count_b;

  int total = 0;
  int bad = 0;
  int acc_cnt_a = 0;
  int acc_cnt_b = 0;

  addsub_result_accumulator #(.ACC_W(12), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_mode(in_mode),
    .in_mag(in_mag), .in_flag(in_flag), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_count(out_count_a),
    .out_sat(out_sat_a)
  );

  addsub_result_accumulator #(.ACC_W(6), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .frame_len(frame_len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_mode(in_mode),
    .in_mag(in_mag), .in_flag(in_flag), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_count(out_count_b),
    .out_sat(out_sat_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  // accept monitor, sampled at the active edge before state updates
  always @(posedge clk) begin
    if (in_valid && in_ready_a) acc_cnt_a <= acc_cnt_a + 1;
    if (in_valid && in_ready_b) acc_cnt_b <= acc_cnt_b + 1;
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit sel_b, input logic [3:0] len);
    frame_len = len;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    frame_len = 4'($urandom_range(0, 15));
  endtask

  task automatic send_word(input bit sel_b, input logic m, input logic [3:0] g,
                           input logic f);
    int n;
    in_valid = 1'b1;
    in_mode = m;
    in_mag = g;
    in_flag = f;
    n = 0;
    while (!(sel_b ? in_ready_b : in_ready_a) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL send_word_timeout: in_ready stayed %0b, required 1", 1'b0);
    end
    tick();
    in_valid = 1'b0;
    in_mode = 1'($urandom_range(0, 1));
    in_mag = 4'($urandom_range(0, 15));
    in_flag = 1'($urandom_range(0, 1));
  endtask

  task automatic finish_frame();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL reset_in_ready_a: got %0b want 0", in_ready_a); end
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL reset_out_valid_a: got %0b want 0", out_valid_a); end
    total++; if (out_sum_a !== 12'd0) begin bad++; $display("FAIL reset_out_sum_a: got %0d want 0", out_sum_a); end
    total++; if (out_count_a !== 4'd0) begin bad++; $display("FAIL reset_out_count_a: got %0d want 0", out_count_a); end
    total++; if (out_sat_a !== 1'b0) begin bad++; $display("FAIL reset_out_sat_a: got %0b want 0", out_sat_a); end
    total++; if (in_ready_b !== 1'b0 || out_valid_b !== 1'b0) begin bad++; $display("FAIL reset_b_hs: got ready=%0b valid=%0b want 0 0", in_ready_b, out_valid_b); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_add();
    do_start(1'b0, 4'd3);
    total++; if (in_ready_a !== 1'b1) begin bad++; $display("FAIL basic_ready_after_start: got %0b want 1", in_ready_a); end
    send_word(1'b0, 1'b0, 4'd9, 1'b0);
    send_word(1'b0, 1'b0, 4'd7, 1'b1);
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL basic_valid_early: got %0b want 0", out_valid_a); end
    send_word(1'b0, 1'b0, 4'd0, 1'b0);
    total++; if (out_valid_a !== 1'b1) begin bad++; $display("FAIL basic_valid_latency: got %0b want 1", out_valid_a); end
    total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL basic_ready_drop: got %0b want 0", in_ready_a); end
    total++; if (out_sum_a !== 12'd32) begin bad++; $display("FAIL basic_sum: got %0d want 32", $signed(out_sum_a)); end
    total++; if (out_count_a !== 4'd3) begin bad++; $display("FAIL basic_count: got %0d want 3", out_count_a); end
    total++; if (out_sat_a !== 1'b0) begin bad++; $display("FAIL basic_sat: got %0b want 0", out_sat_a); end
    finish_frame();
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL basic_release: got %0b want 0", out_valid_a); end
  endtask

  task automatic test_mixed_sub();
    do_start(1'b0, 4'd4);
    send_word(1'b0, 1'b1, 4'd5, 1'b0);
    send_word(1'b0, 1'b1, 4'd12, 1'b1);
    send_word(1'b0, 1'b1, 4'd15, 1'b1);
    send_word(1'b0, 1'b0, 4'd3, 1'b0);
    total++; if (out_valid_a !== 1'b1) begin bad++; $display("FAIL mixed_valid: got %0b want 1", out_valid_a); end
    total++; if (out_sum_a !== 12'hFED) begin bad++; $display("FAIL mixed_sum: got %0d want -19", $signed(out_sum_a)); end
    total++; if (out_count_a !== 4'd4) begin bad++; $display("FAIL mixed_count: got %0d want 4", out_count_a); end
    total++; if (out_sat_a !== 1'b0) begin bad++; $display("FAIL mixed_sat: got %0b want 0", out_sat_a); end
    finish_frame();
  endtask

  task automatic test_saturation();
    do_start(1'b1, 4'd3);
    send_word(1'b1, 1'b0, 4'd14, 1'b1);
    total++; if (out_sum_b !== 6'd30 || out_sat_b !== 1'b0) begin bad++; $display("FAIL sat_word1: got sum=%0d sat=%0b want 30 0", $signed(out_sum_b), out_sat_b); end
    send_word(1'b1, 1'b0, 4'd14, 1'b1);
    total++; if (out_sum_b !== 6'd31 || out_sat_b !== 1'b1) begin bad++; $display("FAIL sat_clamp_pos: got sum=%0d sat=%0b want 31 1", $signed(out_sum_b), out_sat_b); end
    send_word(1'b1, 1'b1, 4'd15, 1'b1);
    total++; if (out_valid_b !== 1'b1) begin bad++; $display("FAIL sat_valid: got %0b want 1", out_valid_b); end
    total++; if (out_sum_b !== 6'd16 || out_sat_b !== 1'b1) begin bad++; $display("FAIL sat_continue: got sum=%0d sat=%0b want 16 1", $signed(out_sum_b), out_sat_b); end
    finish_frame();
    // negative run: -15, -30, -45 -> clamp at -32
    do_start(1'b1, 4'd3);
    total++; if (out_sat_b !== 1'b0 || out_sum_b !== 6'd0) begin bad++; $display("FAIL sat_clear_on_start: got sum=%0d sat=%0b want 0 0", $signed(out_sum_b), out_sat_b); end
    send_word(1'b1, 1'b1, 4'd15, 1'b1);
    send_word(1'b1, 1'b1, 4'd15, 1'b1);
    total++; if (out_sum_b !== 6'h22 || out_sat_b !== 1'b0) begin bad++; $display("FAIL sat_neg_pre: got sum=%0d sat=%0b want -30 0", $signed(out_sum_b), out_sat_b); end
    send_word(1'b1, 1'b1, 4'd15, 1'b1);
    total++; if (out_sum_b !== 6'h20 || out_sat_b !== 1'b1) begin bad++; $display("FAIL sat_clamp_neg: got sum=%0d sat=%0b want -32 1", $signed(out_sum_b), out_sat_b); end
    finish_frame();
  endtask

  task automatic test_stalls();
    int base;
    int gap;
    logic [11:0] held;
    base = acc_cnt_a;
    do_start(1'b0, 4'd4);
    for (int i = 0; i < 4; i++) begin
      gap = $urandom_range(0, 3);
      for (int k = 0; k < gap; k++) tick();
      case (i)
        0: send_word(1'b0, 1'b1, 4'd5, 1'b0);
        1: send_word(1'b0, 1'b1, 4'd12, 1'b1);
        2: send_word(1'b0, 1'b1, 4'd15, 1'b1);
        default: send_word(1'b0, 1'b0, 4'd3, 1'b0);
      endcase
    end
    held = out_sum_a;
    total++; if (held !== 12'hFED) begin bad++; $display("FAIL stall_sum: got %0d want -19", $signed(held)); end
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (out_valid_a !== 1'b1 || out_sum_a !== 12'hFED) begin bad++; $display("FAIL stall_hold: got valid=%0b sum=%0d want 1 -19", out_valid_a, $signed(out_sum_a)); end
    end
    in_valid = 1'b0;
    total++; if (acc_cnt_a - base !== 4) begin bad++; $display("FAIL stall_accepts: got %0d want 4", acc_cnt_a - base); end
    finish_frame();
  endtask

  task automatic test_ignored();
    do_start(1'b0, 4'd0);
    total++; if (in_ready_a !== 1'b0 || out_valid_a !== 1'b0) begin bad++; $display("FAIL ign_len0: got ready=%0b valid=%0b want 0 0", in_ready_a, out_valid_a); end
    do_start(1'b0, 4'd2);
    send_word(1'b0, 1'b0, 4'd1, 1'b0);
    // start during ACCUM must not restart the frame
    do_start(1'b0, 4'd5);
    total++; if (out_count_a !== 4'd1 || out_sum_a !== 12'd1) begin bad++; $display("FAIL ign_start_accum: got count=%0d sum=%0d want 1 1", out_count_a, $signed(out_sum_a)); end
    send_word(1'b0, 1'b0, 4'd2, 1'b0);
    total++; if (out_valid_a !== 1'b1 || out_sum_a !== 12'd3 || out_count_a !== 4'd2) begin bad++; $display("FAIL ign_frame: got valid=%0b sum=%0d count=%0d want 1 3 2", out_valid_a, $signed(out_sum_a), out_count_a); end
    do_start(1'b0, 4'd7);
    total++; if (out_valid_a !== 1'b1 || out_count_a !== 4'd2) begin bad++; $display("FAIL ign_start_done: got valid=%0b count=%0d want 1 2", out_valid_a, out_count_a); end
    finish_frame();
    // earliest restart: start in the first IDLE cycle
    do_start(1'b0, 4'd1);
    total++; if (in_ready_a !== 1'b1 || out_sum_a !== 12'd0) begin bad++; $display("FAIL back_to_back_restart: got ready=%0b sum=%0d want 1 0", in_ready_a, $signed(out_sum_a)); end
    send_word(1'b0, 1'b0, 4'd4, 1'b0);
    finish_frame();
  endtask

  task automatic test_reset_mid_frame();
    do_start(1'b0, 4'd4);
    send_word(1'b0, 1'b0, 4'd10, 1'b0);
    send_word(1'b0, 1'b0, 4'd5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (in_ready_a !== 1'b0 || out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_mid_hs: got ready=%0b valid=%0b want 0 0", in_ready_a, out_valid_a); end
    total++; if (out_sum_a !== 12'd0 || out_count_a !== 4'd0 || out_sat_a !== 1'b0) begin bad++; $display("FAIL rst_mid_regs: got sum=%0d count=%0d sat=%0b want 0 0 0", $signed(out_sum_a), out_count_a, out_sat_a); end
    tick();
    rst_n = 1'b1;
    tick();
    do_start(1'b0, 4'd2);
    send_word(1'b0, 1'b0, 4'd1, 1'b0);
    send_word(1'b0, 1'b1, 4'd4, 1'b1);
    total++; if (out_valid_a !== 1'b1 || out_sum_a !== 12'hFFD || out_count_a !== 4'd2) begin bad++; $display("FAIL rst_new_frame: got valid=%0b sum=%0d count=%0d want 1 -3 2", out_valid_a, $signed(out_sum_a), out_count_a); end
    finish_frame();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_mixed_sub();
    test_saturation();
    test_stalls();
    test_ignored();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
